// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed WIDTHxWIDTH multiplier (radix-2 Booth) and
// WIDTH/WIDTH restoring divider sharing one accumulator/shift datapath.
// Results appear on z_hi/z_lo with a one-cycle done pulse.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_next;

  // acc holds the Booth partial product (mul) or the partial remainder (div);
  // qreg holds the multiplier bits (mul) or the growing quotient (div).
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   mcand;
  logic [WIDTH-1:0] qreg;
  logic             q_1;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;

  logic             b_zero;
  logic             last_step;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_acc;
  logic [WIDTH-1:0] booth_q;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] fix_quo;
  logic [WIDTH-1:0] fix_rem;

  // One Booth step, one restoring-division step and the final sign fix-up,
  // all computed combinationally from the current datapath registers.
  always_comb begin
    b_zero    = (b == '0);
    last_step = (cnt == LAST);
    abs_a     = a[WIDTH-1] ? (~a + 1'b1) : a;
    abs_b     = b[WIDTH-1] ? (~b + 1'b1) : b;

    booth_sum = acc;
    case ({qreg[0], q_1})
      2'b01:   booth_sum = acc + mcand;
      2'b10:   booth_sum = acc - mcand;
      default: booth_sum = acc;
    endcase
    booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_q   = {booth_sum[0], qreg[WIDTH-1:1]};

    div_shift = {acc[WIDTH-1:0], qreg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, dvs};
    div_ok    = ~div_diff[WIDTH];
    div_rem   = div_ok ? div_diff : div_shift;
    div_quo   = {qreg[WIDTH-2:0], div_ok};

    fix_quo   = neg_q ? (~qreg + 1'b1) : qreg;
    fix_rem   = neg_r ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  end

  // State register; clr aborts any operation in flight.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode plus the state-derived busy/done handshake.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!op)        state_next = MUL;
          else if (b_zero) state_next = DONE;
          else            state_next = DIV;
        end
      end
      MUL: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DIV: begin
        busy = 1'b1;
        if (last_step) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on an accepted start, iterate, and write the
  // result registers only on the edge that enters DONE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      acc         <= '0;
      mcand       <= '0;
      qreg        <= '0;
      q_1         <= 1'b0;
      dvs         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      z_hi        <= '0;
      z_lo        <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            cnt         <= '0;
            if (!op) begin
              acc   <= '0;
              mcand <= {a[WIDTH-1], a};
              qreg  <= b;
              q_1   <= 1'b0;
            end else if (b_zero) begin
              z_hi        <= a;
              z_lo        <= '1;
              div_by_zero <= 1'b1;
            end else begin
              acc   <= '0;
              qreg  <= abs_a;
              dvs   <= abs_b;
              neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_r <= a[WIDTH-1];
            end
          end
        end
        MUL: begin
          acc <= booth_acc;
          qreg <= booth_q;
          q_1 <= qreg[0];
          cnt <= cnt + CW'(1);
          if (last_step) begin
            z_hi <= booth_acc[WIDTH-1:0];
            z_lo <= booth_q;
          end
        end
        DIV: begin
          acc  <= div_rem;
          qreg <= div_quo;
          cnt  <= cnt + CW'(1);
        end
        FIX: begin
          z_lo <= fix_quo;
          z_hi <= fix_rem;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
